// File: rtl/alu_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// alu_arbiter_pkg
// Shared definitions for the ALU arbiter slice: ALU opcode encodings, the
// arbiter FSM state encoding and the default datapath widths.
// -----------------------------------------------------------------------------
package alu_arbiter_pkg;

   localparam int DEFAULT_WIDTH = 4;
   localparam int DEFAULT_OPW   = 3;

   // ALU opcode encodings (the arbiter passes every code through undecoded)
   localparam logic [DEFAULT_OPW-1:0] OP_ADD  = 3'd0;
   localparam logic [DEFAULT_OPW-1:0] OP_SUB  = 3'd1;
   localparam logic [DEFAULT_OPW-1:0] OP_NOT  = 3'd2;
   localparam logic [DEFAULT_OPW-1:0] OP_NAND = 3'd3;
   localparam logic [DEFAULT_OPW-1:0] OP_NOR  = 3'd4;
   localparam logic [DEFAULT_OPW-1:0] OP_AND  = 3'd5;
   localparam logic [DEFAULT_OPW-1:0] OP_OR   = 3'd6;
   localparam logic [DEFAULT_OPW-1:0] OP_XOR  = 3'd7;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_RESP = 2'd2
   } state_e;

endpackage

// File: rtl/alu_arbiter_if.sv
// -----------------------------------------------------------------------------
// alu_arbiter_if
// Bundles the request channel, the ALU drive/return bus and the response
// channel of the ALU arbiter.
//   slave  : arbiter side (takes requests, drives the ALU, issues responses)
//   master : requesters + ALU + response consumer side
// Request packing: requester i lives at [i*WIDTH +: WIDTH] / [i*OPW +: OPW].
// -----------------------------------------------------------------------------
interface alu_arbiter_if
   import alu_arbiter_pkg::*;
#(
   parameter int NREQ  = 4,
   parameter int WIDTH = DEFAULT_WIDTH,
   parameter int OPW   = DEFAULT_OPW,
   parameter int IDW   = 2
);

   logic [NREQ-1:0]       req_valid;
   logic [NREQ-1:0]       req_ready;
   logic [NREQ*WIDTH-1:0] req_a;
   logic [NREQ*WIDTH-1:0] req_b;
   logic [NREQ*OPW-1:0]   req_op;

   logic [WIDTH-1:0]      alu_a;
   logic [WIDTH-1:0]      alu_b;
   logic [OPW-1:0]        alu_op;
   logic [WIDTH-1:0]      alu_r;

   logic                  resp_valid;
   logic                  resp_ready;
   logic [IDW-1:0]        resp_id;
   logic [WIDTH-1:0]      resp_r;
   logic                  resp_zero;

   modport slave (
      input  req_valid, req_a, req_b, req_op, alu_r, resp_ready,
      output req_ready, alu_a, alu_b, alu_op, resp_valid, resp_id, resp_r, resp_zero
   );

   modport master (
      output req_valid, req_a, req_b, req_op, alu_r, resp_ready,
      input  req_ready, alu_a, alu_b, alu_op, resp_valid, resp_id, resp_r, resp_zero
   );

endinterface

// File: rtl/alu_arbiter_rr_arbiter.sv
// -----------------------------------------------------------------------------
// alu_arbiter_rr_arbiter
// Purely combinational round-robin picker. Grants the first set bit of req
// searching upward from ptr, wrapping from NREQ-1 back to 0.
//   req     in  NREQ  request vector
//   ptr     in  IDW   search start index (must be < NREQ)
//   gnt     out NREQ  one-hot grant (all zero when nothing requested)
//   gnt_idx out IDW   index of the granted bit
//   any_gnt out 1     some request was granted
// -----------------------------------------------------------------------------
module alu_arbiter_rr_arbiter
   import alu_arbiter_pkg::*;
#(
   parameter int NREQ = 4,
   parameter int IDW  = 2
) (
   input  logic [NREQ-1:0] req,
   input  logic [IDW-1:0]  ptr,
   output logic [NREQ-1:0] gnt,
   output logic [IDW-1:0]  gnt_idx,
   output logic            any_gnt
);

   int idx;

   always_comb begin
      gnt     = '0;
      gnt_idx = '0;
      any_gnt = 1'b0;
      idx     = 0;
      for (int k = 0; k < NREQ; k++) begin
         idx = (int'(ptr) + k) % NREQ;
         if (!any_gnt && req[idx]) begin
            any_gnt      = 1'b1;
            gnt[idx]     = 1'b1;
            gnt_idx      = IDW'(idx);
         end
      end
   end

endmodule

// File: rtl/alu_arbiter.sv
// -----------------------------------------------------------------------------
// alu_arbiter
// Shares one external combinational ALU among NREQ requesters.
// IDLE grants one request round-robin and latches its operands onto the ALU
// inputs; EXEC gives the ALU one full cycle and captures its result; RESP holds
// the tagged result until the consumer accepts it.
//   clk   in   clock, rising edge
//   rst_n in   asynchronous active-low reset
//   bus   slave modport of alu_arbiter_if (requests, ALU bus, responses)
//   busy  out  FSM is not in IDLE
// -----------------------------------------------------------------------------
module alu_arbiter
   import alu_arbiter_pkg::*;
#(
   parameter int NREQ  = 4,
   parameter int WIDTH = DEFAULT_WIDTH,
   parameter int OPW   = DEFAULT_OPW,
   parameter int IDW   = 2
) (
   input  logic          clk,
   input  logic          rst_n,
   alu_arbiter_if.slave  bus,
   output logic          busy
);

   state_e           state_q,      state_d;
   logic [IDW-1:0]   rr_ptr_q,     rr_ptr_d;
   logic [IDW-1:0]   owner_q,      owner_d;
   logic [WIDTH-1:0] alu_a_q,      alu_a_d;
   logic [WIDTH-1:0] alu_b_q,      alu_b_d;
   logic [OPW-1:0]   alu_op_q,     alu_op_d;
   logic [WIDTH-1:0] resp_r_q,     resp_r_d;
   logic [IDW-1:0]   resp_id_q,    resp_id_d;
   logic             resp_valid_q, resp_valid_d;
   logic             resp_zero_q,  resp_zero_d;
   logic             busy_q,       busy_d;

   logic [NREQ-1:0]  gnt;
   logic [IDW-1:0]   gnt_idx;
   logic             any_gnt;

   alu_arbiter_rr_arbiter #(
      .NREQ (NREQ),
      .IDW  (IDW)
   ) u_rr (
      .req     (bus.req_valid),
      .ptr     (rr_ptr_q),
      .gnt     (gnt),
      .gnt_idx (gnt_idx),
      .any_gnt (any_gnt)
   );

   // Accept strobe is only offered while idle, so a request is consumed once.
   assign bus.req_ready = (state_q == ST_IDLE) ? gnt : '0;

   always_comb begin
      state_d      = state_q;
      rr_ptr_d     = rr_ptr_q;
      owner_d      = owner_q;
      alu_a_d      = alu_a_q;
      alu_b_d      = alu_b_q;
      alu_op_d     = alu_op_q;
      resp_r_d     = resp_r_q;
      resp_id_d    = resp_id_q;
      resp_valid_d = resp_valid_q;
      resp_zero_d  = resp_zero_q;

      case (state_q)
         ST_IDLE: begin
            if (any_gnt) begin
               alu_a_d  = bus.req_a[int'(gnt_idx)*WIDTH +: WIDTH];
               alu_b_d  = bus.req_b[int'(gnt_idx)*WIDTH +: WIDTH];
               alu_op_d = bus.req_op[int'(gnt_idx)*OPW +: OPW];
               owner_d  = gnt_idx;
               // Next search starts just past the winner, wrapping at NREQ-1.
               rr_ptr_d = (int'(gnt_idx) == NREQ-1) ? '0 : gnt_idx + 1'b1;
               state_d  = ST_EXEC;
            end
         end
         ST_EXEC: begin
            resp_r_d     = bus.alu_r;
            resp_zero_d  = (bus.alu_r == '0);
            resp_id_d    = owner_q;
            resp_valid_d = 1'b1;
            state_d      = ST_RESP;
         end
         ST_RESP: begin
            if (bus.resp_ready) begin
               resp_valid_d = 1'b0;
               state_d      = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      busy_d = (state_d != ST_IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         rr_ptr_q     <= '0;
         owner_q      <= '0;
         alu_a_q      <= '0;
         alu_b_q      <= '0;
         alu_op_q     <= '0;
         resp_r_q     <= '0;
         resp_id_q    <= '0;
         resp_valid_q <= 1'b0;
         resp_zero_q  <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         rr_ptr_q     <= rr_ptr_d;
         owner_q      <= owner_d;
         alu_a_q      <= alu_a_d;
         alu_b_q      <= alu_b_d;
         alu_op_q     <= alu_op_d;
         resp_r_q     <= resp_r_d;
         resp_id_q    <= resp_id_d;
         resp_valid_q <= resp_valid_d;
         resp_zero_q  <= resp_zero_d;
         busy_q       <= busy_d;
      end
   end

   assign bus.alu_a      = alu_a_q;
   assign bus.alu_b      = alu_b_q;
   assign bus.alu_op     = alu_op_q;
   assign bus.resp_r     = resp_r_q;
   assign bus.resp_id    = resp_id_q;
   assign bus.resp_valid = resp_valid_q;
   assign bus.resp_zero  = resp_zero_q;
   assign busy           = busy_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// -----------------------------------------------------------------------------
// tb_alu_arbiter
// Directed bench for alu_arbiter with a 4-bit ALU attached to the alu_* bus.
// Expected responses are queued when a request is driven and popped when the
// DUT presents a response.
// -----------------------------------------------------------------------------
module tb_alu_arbiter;
   import alu_arbiter_pkg::*;

   logic clk;
   logic rst_n;
   logic busy;
   int   n_checks;
   int   n_errors;
   int   cyc;
   int   last_cyc;

   typedef struct packed {
      logic [1:0] id;
      logic [3:0] r;
      logic       z;
   } exp_t;

   exp_t sb[$];

   alu_arbiter_if #(.NREQ(4), .WIDTH(4), .OPW(3), .IDW(2)) bus ();

   alu_arbiter #(.NREQ(4), .WIDTH(4), .OPW(3), .IDW(2)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave),
      .busy  (busy)
   );

   // The team ALU: 4-bit, wraps on ADD/SUB
   always_comb begin
      bus.alu_r = 4'h0;
      case (bus.alu_op)
         OP_ADD:  bus.alu_r = bus.alu_a + bus.alu_b;
         OP_SUB:  bus.alu_r = bus.alu_a - bus.alu_b;
         OP_NOT:  bus.alu_r = ~bus.alu_a;
         OP_NAND: bus.alu_r = ~(bus.alu_a & bus.alu_b);
         OP_NOR:  bus.alu_r = ~(bus.alu_a | bus.alu_b);
         OP_AND:  bus.alu_r = bus.alu_a & bus.alu_b;
         OP_OR:   bus.alu_r = bus.alu_a | bus.alu_b;
         OP_XOR:  bus.alu_r = bus.alu_a ^ bus.alu_b;
         default: bus.alu_r = 4'h0;
      endcase
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Sample/drive point: 1 time unit after the falling edge
   task automatic next();
      @(negedge clk);
      #1;
   endtask

   task automatic set_req(input int i, input logic v, input logic [3:0] a, input logic [3:0] b,
                          input logic [2:0] op);
      bus.req_valid[i]      = v;
      bus.req_a[i*4 +: 4]   = a;
      bus.req_b[i*4 +: 4]   = b;
      bus.req_op[i*3 +: 3]  = op;
   endtask

   task automatic push_exp(input int id, input int r);
      exp_t e;
      e.id = 2'(id);
      e.r  = 4'(r);
      e.z  = (r == 0);
      sb.push_back(e);
   endtask

   task automatic wait_grant(input string tag);
      for (int k = 0; k < 12 && bus.req_ready == '0; k++) next();
      check({tag, "_grant_seen"}, 32'(|bus.req_ready), 1);
   endtask

   task automatic wait_resp(input string tag);
      exp_t e;
      for (int k = 0; k < 12 && !bus.resp_valid; k++) next();
      check({tag, "_resp_seen"}, 32'(bus.resp_valid), 1);
      check({tag, "_sb_nonempty"}, 32'(sb.size() > 0), 1);
      if (sb.size() > 0) begin
         e = sb.pop_front();
         check({tag, "_resp_id"},   32'(bus.resp_id),   32'(e.id));
         check({tag, "_resp_r"},    32'(bus.resp_r),    32'(e.r));
         check({tag, "_resp_zero"}, 32'(bus.resp_zero), 32'(e.z));
      end
   endtask

   // One complete operation with resp_ready held high; expects IDLE on entry
   task automatic do_op(input string tag, input int i, input logic [3:0] a, input logic [3:0] b,
                        input logic [2:0] op, input int r);
      push_exp(i, r);
      set_req(i, 1'b1, a, b, op);
      #1;
      wait_grant(tag);
      check({tag, "_req_ready"}, 32'(bus.req_ready), 1 << i);
      next();
      bus.req_valid[i] = 1'b0;
      check({tag, "_exec_alu_a"},  32'(bus.alu_a),  32'(a));
      check({tag, "_exec_alu_b"},  32'(bus.alu_b),  32'(b));
      check({tag, "_exec_alu_op"}, 32'(bus.alu_op), 32'(op));
      check({tag, "_exec_busy"},   32'(busy), 1);
      check({tag, "_exec_rvalid"}, 32'(bus.resp_valid), 0);
      next();
      check({tag, "_latency"}, 32'(bus.resp_valid), 1);
      wait_resp(tag);
      next();
      check({tag, "_idle_rvalid"}, 32'(bus.resp_valid), 0);
      check({tag, "_idle_busy"},   32'(busy), 0);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_alu_a"},      32'(bus.alu_a), 0);
      check({tag, "_alu_b"},      32'(bus.alu_b), 0);
      check({tag, "_alu_op"},     32'(bus.alu_op), 0);
      check({tag, "_resp_r"},     32'(bus.resp_r), 0);
      check({tag, "_resp_id"},    32'(bus.resp_id), 0);
      check({tag, "_resp_valid"}, 32'(bus.resp_valid), 0);
      check({tag, "_resp_zero"},  32'(bus.resp_zero), 0);
      check({tag, "_busy"},       32'(busy), 0);
      check({tag, "_req_ready"},  32'(bus.req_ready), 0);
   endtask

   initial begin
      int fair_order[6];
      n_checks = 0;
      n_errors = 0;
      last_cyc = 0;
      fair_order = '{0, 1, 2, 3, 0, 1};
      rst_n = 1'b0;
      bus.req_valid  = '0;
      bus.req_a      = '0;
      bus.req_b      = '0;
      bus.req_op     = '0;
      bus.resp_ready = 1'b0;
      next();
      next();
      check_all_zero("reset");
      rst_n = 1'b1;
      next();

      // Reset while an operation is in EXEC: it must vanish without response
      set_req(0, 1'b1, 4'd7, 4'd3, OP_ADD);
      #1;
      check("rst_mid_grant", 32'(bus.req_ready), 'b0001);
      next();
      bus.req_valid[0] = 1'b0;
      check("rst_mid_exec_busy", 32'(busy), 1);
      check("rst_mid_exec_alu_a", 32'(bus.alu_a), 7);
      rst_n = 1'b0;
      #1;
      check_all_zero("rst_mid_async");
      next();
      check("rst_mid_hold_rvalid", 32'(bus.resp_valid), 0);
      rst_n = 1'b1;
      for (int k = 0; k < 3; k++) begin
         next();
         check("rst_mid_no_resp", 32'(bus.resp_valid), 0);
         check("rst_mid_idle", 32'(busy), 0);
      end

      // Fairness: all four valid; rotation from rr_ptr=0, one grant per 3 cycles
      bus.resp_ready = 1'b1;
      for (int i = 0; i < 4; i++) set_req(i, 1'b1, 4'(i + 1), 4'd1, OP_ADD);
      for (int n = 0; n < 6; n++) push_exp(fair_order[n], fair_order[n] + 2);
      #1;
      for (int n = 0; n < 6; n++) begin
         wait_grant("fair");
         check("fair_gnt", 32'(bus.req_ready), 1 << fair_order[n]);
         if (n > 0) check("fair_gap", 32'(cyc - last_cyc), 3);
         last_cyc = cyc;
         next();
         if (n == 5) bus.req_valid = '0;
         wait_resp("fair");
      end
      next();

      // Single request, then nothing more must come out of it
      do_op("single", 1, 4'd7, 4'd3, OP_ADD, 'hA);
      for (int k = 0; k < 3; k++) begin
         check("single_once_rvalid", 32'(bus.resp_valid), 0);
         check("single_once_ready", 32'(bus.req_ready), 0);
         next();
      end

      // Wrap-around and zero flag
      do_op("sub_wrap", 0, 4'd3, 4'd5, OP_SUB, 'hE);
      do_op("xor_zero", 0, 4'd9, 4'd9, OP_XOR, 0);
      do_op("add_wrap", 2, 4'hF, 4'd1, OP_ADD, 0);

      // Backpressure: rr_ptr is 3 here, so req3 wins over req0
      push_exp(3, 'h7);
      push_exp(0, 'h7);
      bus.resp_ready = 1'b0;
      set_req(0, 1'b1, 4'd5, 4'd2, OP_ADD);
      set_req(3, 1'b1, 4'hC, 4'hA, OP_NAND);
      #1;
      check("bp_gnt3", 32'(bus.req_ready), 'b1000);
      next();
      bus.req_valid[3] = 1'b0;
      #1;
      check("bp_exec_no_ready", 32'(bus.req_ready), 0);
      next();
      wait_resp("bp3");
      for (int k = 0; k < 5; k++) begin
         check("bp_hold_valid", 32'(bus.resp_valid), 1);
         check("bp_hold_r", 32'(bus.resp_r), 'h7);
         check("bp_hold_id", 32'(bus.resp_id), 3);
         check("bp_hold_no_ready", 32'(bus.req_ready), 0);
         if (k < 4) next();
      end
      bus.resp_ready = 1'b1;
      #1;
      check("bp_hs_no_ready", 32'(bus.req_ready), 0);
      next();
      check("bp_after_rvalid", 32'(bus.resp_valid), 0);
      check("bp_after_gnt0", 32'(bus.req_ready), 'b0001);
      next();
      bus.req_valid[0] = 1'b0;
      check("bp_req0_alu_a", 32'(bus.alu_a), 5);
      next();
      wait_resp("bp0");
      next();

      // Opcode sweep on requester 0 with A=6 B=3
      do_op("op_add",  0, 4'd6, 4'd3, OP_ADD,  'h9);
      do_op("op_sub",  0, 4'd6, 4'd3, OP_SUB,  'h3);
      do_op("op_not",  0, 4'd6, 4'd3, OP_NOT,  'h9);
      do_op("op_nand", 0, 4'd6, 4'd3, OP_NAND, 'hD);
      do_op("op_nor",  0, 4'd6, 4'd3, OP_NOR,  'h8);
      do_op("op_and",  0, 4'd6, 4'd3, OP_AND,  'h2);
      do_op("op_or",   0, 4'd6, 4'd3, OP_OR,   'h7);
      do_op("op_xor",  0, 4'd6, 4'd3, OP_XOR,  'h5);

      check("sb_drained", 32'(sb.size()), 0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares one 4-bit combinational ALU datapath (3-bit opcode, 8 ops: ADD, SUB, NOT, NAND, NOR, AND, OR, XOR) among NREQ requesters.
- Round-robin grant, operand latching, drive of the ALU inputs, result capture, and a valid/ready response channel tagged with the requester id.
- Sits between requesting engines and the single ALU instance. The ALU itself stays outside this block and connects through the alu_* ports.

Parameters:
- NREQ, 4, number of requesters (2..8).
- WIDTH, 4, operand and result width; must match the ALU.
- OPW, 3, opcode width; must match the ALU.
- IDW, 2, response id width; ceil(log2(NREQ)).

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NREQ  per-requester request valid.
- req_ready  out  NREQ  per-requester accept strobe; at most one bit high.
- req_a  in  NREQ*WIDTH  operand A, requester i at [i*WIDTH +: WIDTH].
- req_b  in  NREQ*WIDTH  operand B, same packing.
- req_op  in  NREQ*OPW  opcode, requester i at [i*OPW +: OPW].
- alu_a  out  WIDTH  registered operand A to the ALU.
- alu_b  out  WIDTH  registered operand B to the ALU.
- alu_op  out  OPW  registered opcode to the ALU.
- alu_r  in  WIDTH  ALU result (combinational from alu_a/alu_b/alu_op).
- resp_valid  out  1  response valid.
- resp_ready  in  1  response consumer ready.
- resp_id  out  IDW  index of the requester that owns the response.
- resp_r  out  WIDTH  captured result.
- resp_zero  out  1  captured result equals 0.
- busy  out  1  FSM not in IDLE.

Behaviour:
- Reset (rst_n low, asynchronous):
  - State = IDLE; rr_ptr = 0.
  - alu_a, alu_b, alu_op, resp_r, resp_id = 0; resp_valid = 0; resp_zero = 0; busy = 0; req_ready = 0.
- FSM states: IDLE -> EXEC -> RESP -> IDLE.
- IDLE:
  - If any req_valid is high, grant the first set bit searching from rr_ptr upward, with wrap at NREQ-1 -> 0.
  - req_ready[g] is combinational, high in this cycle only; the handshake completes on this edge.
  - On the edge: latch req_a[g], req_b[g], req_op[g] into alu_a/alu_b/alu_op; store g as the owner id; set rr_ptr = (g+1) mod NREQ; go to EXEC.
  - If no valid is high, stay in IDLE with all registers unchanged.
- EXEC:
  - Exactly one cycle; alu_* are stable for the whole cycle.
  - At the end of the cycle: resp_r <= alu_r; resp_zero <= (alu_r == 0); resp_id <= owner; resp_valid <= 1; go to RESP.
- RESP:
  - Hold resp_valid and the resp_* payload stable until resp_ready is high.
  - On the handshake edge: resp_valid <= 0; go to IDLE.
  - req_ready stays 0 throughout EXEC and RESP.
- Latency: accept edge to resp_valid high is 1 cycle. Minimum issue interval is 3 cycles per operation.
- alu_a/alu_b/alu_op hold their last values outside EXEC. No gating.
- Arithmetic: ADD and SUB wrap modulo 2^WIDTH, with no carry or borrow output. This block does not decode opcodes; all 2^OPW codes pass through unchanged.
- Boundary conditions:
  - All requesters valid: strict rotation 0,1,2,3,0...
  - A single requester valid repeatedly is granted every 3 cycles (when resp_ready is held high).
  - A requester may drop req_valid before its grant; no state is kept for it.
  - A request whose valid is high together with req_ready is consumed once only.
  - resp_ready high while resp_valid is low is ignored.
  - rst_n asserted in any state returns to IDLE immediately; an in-flight operation is discarded with no response.
- Requesters must hold req_a/req_b/req_op stable while req_valid is high.

Decomposition:
- Shared package: ALU opcode constants (OP_ADD=0, OP_SUB=1, OP_NOT=2, OP_NAND=3, OP_NOR=4, OP_AND=5, OP_OR=6, OP_XOR=7); FSM state encoding (IDLE=0, EXEC=1, RESP=2); default WIDTH and OPW.
- Sub-module: rr_arbiter. Purely combinational round-robin picker: inputs req vector and rr_ptr; outputs a one-hot grant, the grant index, and an any-grant flag. It is reused elsewhere.
- The bench connects the team's ALU to the alu_* ports.

Test Plan:
- Reset mid-EXEC: req0 ADD A=7 B=3, assert rst_n low during EXEC -> all outputs 0, no resp_valid ever, after release state IDLE and rr_ptr=0.
- Single request: req1 ADD A=7 B=3, resp_ready=1 -> req_ready=4'b0010 for 1 cycle, next cycle resp_valid=1, resp_r=4'hA, resp_id=1, resp_zero=0.
- Wrap and zero flag: req0 SUB A=3 B=5 -> resp_r=4'hE; req0 XOR A=9 B=9 -> resp_r=0, resp_zero=1; req2 ADD A=F B=1 -> resp_r=0, resp_zero=1.
- Fairness: all four req_valid held high, resp_ready=1 -> grant order 0,1,2,3,0,1, one grant per 3 cycles, resp_id in that order.
- Backpressure: req3 NAND A=C B=A, resp_ready=0 for 5 cycles -> resp_valid and resp_r=4'h7 stable for 5 cycles; req0 held valid gets no req_ready until 1 cycle after resp handshake.
- Opcode sweep: req0 A=6 B=3, opcodes 0..7 in sequence -> resp_r = 9, 3, 9, D, 8, 2, 7, 5.
